signal_qualify_filter: RTL and testbench
========================================

Name: signal_qualify_filter

Overview:
- Input conditioner and the counterpart of the team's pulse-extension block: that block lengthens pulses, this one qualifies them.
- Propagates a level change on signal_in only after the new level has been sampled for cfg_qual_count consecutive clocks.
- Rejects glitches, counts them, and emits one-cycle edge strobes for the filtered level.
- Sits between already-synchronised status/request inputs and the control FSMs that consume them.

Parameters:
- COUNT_BW, 10, width of the qualification counter and of cfg_qual_count.
- GLITCH_BW, 8, width of the saturating glitch counter.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- signal_in  input  1  raw level; synchronous to clock.
- cfg_qual_count  input  COUNT_BW  consecutive samples N needed to accept a new level; 0 = bypass.
- glitch_clear  input  1  synchronous clear of glitch_count.
- signal_out  output  1  filtered level.
- rise_pulse  output  1  one-cycle strobe when the filtered level goes 0->1.
- fall_pulse  output  1  one-cycle strobe when the filtered level goes 1->0.
- glitch_count  output  GLITCH_BW  number of rejected transitions; saturates at all-ones.

Behaviour:
- Reset: state STABLE_LOW, qual counter 0, filtered level 0, rise_pulse/fall_pulse 0, glitch_count 0.
- States: STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW. Encoding and state constants come from the package. Unused encodings go to STABLE_LOW with the filtered level cleared.
- STABLE_LOW:
  - signal_in=1 and N==1: filtered level<=1, go to STABLE_HIGH.
  - signal_in=1 and N>1: counter<=1, go to QUAL_HIGH.
- QUAL_HIGH:
  - signal_in=0: go to STABLE_LOW, counter<=0, glitch_count+1.
  - Otherwise, counter>=N-1: filtered level<=1, go to STABLE_HIGH, counter<=0.
  - Otherwise: counter+1.
  - The >= compare tolerates cfg_qual_count being lowered mid-qualification.
- STABLE_HIGH and QUAL_LOW mirror STABLE_LOW and QUAL_HIGH with levels inverted. A rejected low-going glitch also increments glitch_count.
- Latency for N>=1: if signal_in changes before edge t and holds, signal_out changes after edge t+N-1, i.e. N cycles after the input change. A level held for N-1 samples is rejected.
- N==0 bypass: signal_out = signal_in combinationally. The FSM keeps tracking with N treated as 1, so leaving bypass causes no spurious strobe.
- rise_pulse/fall_pulse: registered. They assert in the same cycle signal_out changes, including in bypass, where the strobes come from the edge detector on signal_in.
- glitch_count:
  - Saturates at 2^GLITCH_BW-1.
  - glitch_clear takes priority over a simultaneous increment; the result is 0.
- Counter width: compares use full COUNT_BW. N-1 is computed only when N>=1.
- cfg_qual_count is sampled every cycle. A change mid-qualification applies immediately to the compare and never restarts the count.
- Asynchronous reset mid-qualification discards the pending level; the output returns to 0.

Decomposition:
- Package signal_qualify_pkg holds the state localparams/typedef (2 bits) and the default COUNT_BW/GLITCH_BW.
- Sub-module sat_counter (GLITCH_BW-wide, inc/clr, saturating) holds glitch_count. It is reusable by other status blocks.
- Edge detection and the FSM stay in the top module.

Test Plan:
- N=4, signal_in 0->1 held 10 cycles -> signal_out rises 4 cycles after the input edge; rise_pulse high exactly 1 cycle; glitch_count 0.
- N=4, high pulse of 3 cycles -> signal_out stays 0, no strobes, glitch_count=1. Repeat with a 4-cycle pulse -> accepted, rise_pulse then fall_pulse 4 cycles after the input fall.
- N=0 -> signal_out follows signal_in combinationally, strobes track input edges. Switch to N=2 while the input is high -> no spurious fall/rise.
- N=1 -> output is the input delayed 1 cycle; a 1-cycle pulse is passed.
- GLITCH_BW=8, inject 300 three-cycle glitches with N=5 -> glitch_count saturates at 255. glitch_clear coincident with a glitch -> 0.
- N=8 set, QUAL_HIGH counter at 5, N lowered to 4 -> accept on the next edge. Assert reset_n low mid-QUAL_LOW -> signal_out=0, glitch_count=0 immediately.

Source files
------------

// File: rtl/signal_qualify_filter_pkg.sv
// Shared state encoding and default widths for the signal qualification filter.
package signal_qualify_pkg;

    localparam int unsigned DEFAULT_COUNT_BW  = 10;
    localparam int unsigned DEFAULT_GLITCH_BW = 8;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        QUAL_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        QUAL_LOW    = 2'b10
    } qual_state_t;

endpackage

// File: rtl/signal_qualify_filter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/signal_qualify_filter.sv
// Glitch filter: a new input level is propagated only after N consecutive samples.
module signal_qualify_filter
    import signal_qualify_pkg::*;
#(
    parameter int unsigned COUNT_BW  = DEFAULT_COUNT_BW,
    parameter int unsigned GLITCH_BW = DEFAULT_GLITCH_BW
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 signal_in,
    input  logic [COUNT_BW-1:0]  cfg_qual_count,
    input  logic                 glitch_clear,
    output logic                 signal_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [GLITCH_BW-1:0] glitch_count
);

    qual_state_t         state_q, state_d;
    logic [COUNT_BW-1:0] count_q, count_d;
    logic [COUNT_BW-1:0] n_eff, n_last;
    logic                level_q, level_d;
    logic                bypass, single, glitch_inc;

    // Bypass keeps the FSM tracking as N=1 so leaving bypass causes no strobe.
    assign bypass = (cfg_qual_count == '0);
    assign n_eff  = bypass ? COUNT_BW'(1) : cfg_qual_count;
    assign n_last = n_eff - COUNT_BW'(1);
    assign single = (n_eff == COUNT_BW'(1));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        level_d    = level_q;
        glitch_inc = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (signal_in) begin
                    if (single) begin
                        level_d = 1'b1;
                        state_d = STABLE_HIGH;
                        count_d = '0;
                    end else begin
                        count_d = COUNT_BW'(1);
                        state_d = QUAL_HIGH;
                    end
                end
            end
            QUAL_HIGH: begin
                if (!signal_in) begin
                    state_d    = STABLE_LOW;
                    count_d    = '0;
                    glitch_inc = 1'b1;
                end else if (count_q >= n_last) begin
                    level_d = 1'b1;
                    state_d = STABLE_HIGH;
                    count_d = '0;
                end else begin
                    count_d = count_q + COUNT_BW'(1);
                end
            end
            STABLE_HIGH: begin
                if (!signal_in) begin
                    if (single) begin
                        level_d = 1'b0;
                        state_d = STABLE_LOW;
                        count_d = '0;
                    end else begin
                        count_d = COUNT_BW'(1);
                        state_d = QUAL_LOW;
                    end
                end
            end
            QUAL_LOW: begin
                if (signal_in) begin
                    state_d    = STABLE_HIGH;
                    count_d    = '0;
                    glitch_inc = 1'b1;
                end else if (count_q >= n_last) begin
                    level_d = 1'b0;
                    state_d = STABLE_LOW;
                    count_d = '0;
                end else begin
                    count_d = count_q + COUNT_BW'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                count_d = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= STABLE_LOW;
            count_q    <= '0;
            level_q    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            level_q    <= level_d;
            rise_pulse <= level_d & ~level_q;
            fall_pulse <= ~level_d & level_q;
        end
    end

    assign signal_out = bypass ? signal_in : level_q;

    sat_counter #(
        .WIDTH (GLITCH_BW)
    ) u_glitch_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (glitch_inc),
        .clr     (glitch_clear),
        .count   (glitch_count)
    );

endmodule

// File: tb/tb_signal_qualify_filter.sv
// Directed, table-driven bench for signal_qualify_filter with hand-computed expectations.
module tb_signal_qualify_filter;

    logic       clock;
    logic       reset_n;
    logic       signal_in;
    logic [9:0] cfg_qual_count;
    logic       glitch_clear;
    logic       signal_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic       sig_in;
        logic [9:0] cfg;
        logic       clr;
        logic       exp_out;
        logic       exp_rise;
        logic       exp_fall;
        logic [7:0] exp_glitch;
    } vec_t;

    vec_t vecs[$];

    signal_qualify_filter #(
        .COUNT_BW  (10),
        .GLITCH_BW (8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .signal_in      (signal_in),
        .cfg_qual_count (cfg_qual_count),
        .glitch_clear   (glitch_clear),
        .signal_out     (signal_out),
        .rise_pulse     (rise_pulse),
        .fall_pulse     (fall_pulse),
        .glitch_count   (glitch_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic [9:0] n, input logic c,
                       input logic o, input logic r, input logic f, input logic [7:0] g);
        vec_t v;
        v.sig_in = s; v.cfg = n; v.clr = c;
        v.exp_out = o; v.exp_rise = r; v.exp_fall = f; v.exp_glitch = g;
        vecs.push_back(v);
    endtask

    // Drive inputs, advance one clock, land 1 time unit after the edge.
    task automatic step(input logic s, input logic [9:0] n, input logic c);
        signal_in      = s;
        cfg_qual_count = n;
        glitch_clear   = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int unsigned noisy;
        reset_n        = 1'b0;
        signal_in      = 1'b0;
        cfg_qual_count = 10'd4;
        glitch_clear   = 1'b0;

        #12;
        check("reset_out",    signal_out,   0);
        check("reset_rise",   rise_pulse,   0);
        check("reset_fall",   fall_pulse,   0);
        check("reset_glitch", glitch_count, 0);
        reset_n = 1'b1;

        // N=4: rise after 4 samples, then a qualified fall
        for (int i = 0; i < 3; i++) add(1, 4, 0, 0, 0, 0, 0);
        add(1, 4, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 4, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4, 0, 1, 0, 0, 0);
        add(0, 4, 0, 0, 0, 1, 0);
        add(0, 4, 0, 0, 0, 0, 0);
        // 3-cycle high pulse rejected
        for (int i = 0; i < 3; i++) add(1, 4, 0, 0, 0, 0, 0);
        add(0, 4, 0, 0, 0, 0, 1);
        add(0, 4, 0, 0, 0, 0, 1);
        // 4-cycle pulse accepted, fall 4 cycles after input fall
        for (int i = 0; i < 3; i++) add(1, 4, 0, 0, 0, 0, 1);
        add(1, 4, 0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 4, 0, 1, 0, 0, 1);
        add(0, 4, 0, 0, 0, 1, 1);
        // bypass: combinational output, strobes on input edges
        add(0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1, 1, 0, 1);
        // leave bypass while high: no strobes
        add(1, 2, 0, 1, 0, 0, 1);
        add(1, 2, 0, 1, 0, 0, 1);
        // N=1: one-cycle delay, single-cycle pulse passes
        add(0, 1, 0, 0, 0, 1, 1);
        add(1, 1, 0, 1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1);
        // N=3: low-going glitch counted, then clear
        add(1, 3, 0, 0, 0, 0, 1);
        add(1, 3, 0, 0, 0, 0, 1);
        add(1, 3, 0, 1, 1, 0, 1);
        add(0, 3, 0, 1, 0, 0, 1);
        add(1, 3, 0, 1, 0, 0, 2);
        add(1, 3, 0, 1, 0, 0, 2);
        add(1, 3, 1, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].sig_in, vecs[i].cfg, vecs[i].clr);
            check($sformatf("v%0d_out", i),    signal_out,   vecs[i].exp_out);
            check($sformatf("v%0d_rise", i),   rise_pulse,   vecs[i].exp_rise);
            check($sformatf("v%0d_fall", i),   fall_pulse,   vecs[i].exp_fall);
            check($sformatf("v%0d_glitch", i), glitch_count, vecs[i].exp_glitch);
        end

        // Saturation: 300 three-cycle glitches at N=5
        step(0, 1, 0);
        check("sat_pre_out", signal_out, 0);
        noisy = 0;
        for (int g = 0; g < 300; g++) begin
            for (int k = 0; k < 3; k++) begin
                step(1, 5, 0);
                if (signal_out || rise_pulse || fall_pulse) noisy++;
            end
            step(0, 5, 0);
            if (signal_out || rise_pulse || fall_pulse) noisy++;
        end
        check("sat_quiet", noisy, 0);
        check("sat_count", glitch_count, 255);
        for (int k = 0; k < 3; k++) step(1, 5, 0);
        step(0, 5, 1);
        check("clr_priority", glitch_count, 0);
        glitch_clear = 1'b0;

        // N lowered from 8 to 4 with counter at 5: accept on next edge
        for (int k = 0; k < 5; k++) step(1, 8, 0);
        check("lower_pre_out", signal_out, 0);
        step(1, 4, 0);
        check("lower_out",  signal_out, 1);
        check("lower_rise", rise_pulse, 1);

        // Build a nonzero glitch count, then reset mid QUAL_LOW
        step(1, 3, 0);
        step(0, 3, 0);
        step(1, 3, 0);
        check("pre_rst_glitch", glitch_count, 1);
        step(0, 3, 0);
        check("qual_low_out", signal_out, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_out",    signal_out,   0);
        check("rst_glitch", glitch_count, 0);
        #2 reset_n = 1'b1;
        step(0, 3, 0);
        check("post_rst_out",  signal_out, 0);
        check("post_rst_fall", fall_pulse, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
